fsm1_rsp: RTL and testbench

FSM1_RSP -- requirements
Module: fsm1_rsp

---
 rtl/fsm1_rsp.sv | 110 +++++++++++
 tb/tb_fsm1_rsp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm1_rsp.sv
// Read-responder FSM: fetches one word from the backend per initiator read and holds it until ds.
// Optional timeout/error path enabled by defining FSM1_RSP_TIMEOUT_EN.
module fsm1_rsp #(
   parameter int DW       = 8,
   parameter int MIN_WAIT = 2,
   parameter int TIMEOUT  = 16
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          rd,
   input  logic          ds,
   output logic          ws,
   output logic [DW-1:0] rdata,
   output logic          rvalid,
   output logic          err,
   output logic [7:0]    xfer_cnt,
   output logic          be_req,
   input  logic          be_ack,
   input  logic [DW-1:0] be_data
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;

   localparam logic [7:0] MIN_W = 8'(MIN_WAIT);
`ifdef FSM1_RSP_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
`else
   // Counter only needs to reach the acceptance threshold when no timeout exists.
   localparam logic [7:0] WCNT_SAT = 8'((MIN_WAIT < TIMEOUT) ? MIN_WAIT : TIMEOUT - 1);
`endif

   state_t     state;
   logic [7:0] wcnt;
   logic       accept;

   assign accept = be_ack && (wcnt >= MIN_W);

`ifndef FSM1_RSP_TIMEOUT_EN
   assign err = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         wcnt     <= 8'd0;
         ws       <= 1'b0;
         rvalid   <= 1'b0;
         be_req   <= 1'b0;
         rdata    <= '0;
         xfer_cnt <= 8'd0;
`ifdef FSM1_RSP_TIMEOUT_EN
         err      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (rd) begin
                  state  <= FETCH;
                  wcnt   <= 8'd0;
                  be_req <= 1'b1;
                  ws     <= 1'b1;
               end
            end
            FETCH: begin
               // An accepted ack takes priority over the timeout in the same cycle.
               if (accept) begin
                  state  <= HOLD;
                  rdata  <= be_data;
                  be_req <= 1'b0;
                  ws     <= 1'b0;
                  rvalid <= 1'b1;
               end
`ifdef FSM1_RSP_TIMEOUT_EN
               else if (wcnt == TIMEOUT_LAST) begin
                  state  <= ERR;
                  be_req <= 1'b0;
                  ws     <= 1'b0;
                  err    <= 1'b1;
               end else begin
                  wcnt <= wcnt + 8'd1;
               end
`else
               else if (wcnt < WCNT_SAT) begin
                  wcnt <= wcnt + 8'd1;
               end
`endif
            end
            HOLD: begin
               if (ds) begin
                  state    <= IDLE;
                  rvalid   <= 1'b0;
                  xfer_cnt <= xfer_cnt + 8'd1;
               end
            end
            ERR: begin
`ifdef FSM1_RSP_TIMEOUT_EN
               if (ds) begin
                  state <= IDLE;
                  err   <= 1'b0;
               end
`else
               state <= IDLE;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fsm1_rsp.sv
// Directed self-checking bench for fsm1_rsp (default parameters); timeout cases
// run when FSM1_RSP_TIMEOUT_EN is defined, otherwise the indefinite-wait case runs.
`timescale 1ns/1ps
module tb_fsm1_rsp;
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       rd = 1'b0;
   logic       ds = 1'b0;
   logic       ws;
   logic [7:0] rdata;
   logic       rvalid;
   logic       err;
   logic [7:0] xfer_cnt;
   logic       be_req;
   logic       be_ack = 1'b0;
   logic [7:0] be_data = 8'h00;

   int errors = 0;
   int checks = 0;

   fsm1_rsp #(.DW(8), .MIN_WAIT(2), .TIMEOUT(16)) dut (
      .clock(clock), .reset_n(reset_n), .rd(rd), .ds(ds), .ws(ws),
      .rdata(rdata), .rvalid(rvalid), .err(err), .xfer_cnt(xfer_cnt),
      .be_req(be_req), .be_ack(be_ack), .be_data(be_data)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   // Count cycles with ws high after entering FETCH (bounded).
   task automatic count_ws(output int n);
      n = 0;
      while (ws === 1'b1 && n < 200) begin
         n++;
         tick();
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #12;
      chk("reset_ws", ws, 0);
      chk("reset_rvalid", rvalid, 0);
      chk("reset_err", err, 0);
      chk("reset_bereq", be_req, 0);
      chk("reset_rdata", rdata, 0);
      chk("reset_xfer", xfer_cnt, 0);
      reset_n = 1'b1;
      tick();
      $display("reset: ws=%0b rvalid=%0b xfer=%0d", ws, rvalid, xfer_cnt);
   endtask

   task automatic test_basic_read();
      int n;
      be_ack = 1'b1; be_data = 8'hA5; rd = 1'b1;
      tick();
      chk("basic_bereq_fetch", be_req, 1);
      rd = 1'b0;
      count_ws(n);
      chk("basic_ws_cycles", n, 3);
      chk("basic_rvalid", rvalid, 1);
      chk("basic_rdata", rdata, 8'hA5);
      chk("basic_bereq_hold", be_req, 0);
      be_ack = 1'b0;
      ds = 1'b1; tick(); ds = 1'b0;
      chk("basic_rvalid_after_ds", rvalid, 0);
      chk("basic_xfer", xfer_cnt, 1);
      $display("basic read: ws_cycles=%0d rdata=%0h xfer=%0d", n, rdata, xfer_cnt);
   endtask

   task automatic test_slow_backend();
      int n = 0;
      rd = 1'b1; be_data = 8'h3C;
      tick();
      chk("slow_rdata_retained_fetch", rdata, 8'hA5);
      rd = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (ws === 1'b1) n++;
         ds = (i == 2);
         tick();
      end
      ds = 1'b0;
      chk("slow_still_fetch", be_req, 1);
      be_ack = 1'b1;
      if (ws === 1'b1) n++;
      tick();
      chk("slow_ws_cycles", n, 7);
      chk("slow_ws_low", ws, 0);
      chk("slow_bereq_low", be_req, 0);
      chk("slow_rdata", rdata, 8'h3C);
      chk("slow_rvalid", rvalid, 1);
      be_ack = 1'b0; be_data = 8'h00;
      tick();
      chk("slow_rdata_stable_hold", rdata, 8'h3C);
      ds = 1'b1; tick(); ds = 1'b0;
      chk("slow_xfer", xfer_cnt, 2);
      chk("slow_rdata_retained_idle", rdata, 8'h3C);
      $display("slow backend: ws_cycles=%0d rdata=%0h xfer=%0d", n, rdata, xfer_cnt);
   endtask

`ifdef FSM1_RSP_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      rd = 1'b1; be_ack = 1'b0;
      tick();
      rd = 1'b0;
      count_ws(n);
      chk("to_ws_cycles", n, 16);
      chk("to_err", err, 1);
      chk("to_bereq", be_req, 0);
      chk("to_rvalid", rvalid, 0);
      ds = 1'b1; tick(); ds = 1'b0;
      chk("to_err_clear", err, 0);
      chk("to_xfer_unchanged", xfer_cnt, 2);
      $display("timeout: ws_cycles=%0d err_cleared=%0b xfer=%0d", n, err, xfer_cnt);
   endtask

   task automatic test_race();
      rd = 1'b1; be_ack = 1'b0; be_data = 8'h5A;
      tick();
      rd = 1'b0;
      repeat (15) tick();
      be_ack = 1'b1;
      tick();
      chk("race_rvalid", rvalid, 1);
      chk("race_err", err, 0);
      chk("race_rdata", rdata, 8'h5A);
      be_ack = 1'b0;
      ds = 1'b1; tick(); ds = 1'b0;
      chk("race_xfer", xfer_cnt, 3);
      $display("race: rvalid=%0b err=%0b xfer=%0d", rvalid, err, xfer_cnt);
   endtask
`else
   task automatic test_no_timeout();
      int hi = 0;
      rd = 1'b1; be_ack = 1'b0; be_data = 8'h77;
      tick();
      rd = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (ws === 1'b1 && err === 1'b0 && be_req === 1'b1) hi++;
         tick();
      end
      chk("nto_wait_cycles", hi, 40);
      be_ack = 1'b1;
      tick();
      chk("nto_rvalid", rvalid, 1);
      chk("nto_rdata", rdata, 8'h77);
      be_ack = 1'b0;
      ds = 1'b1; tick(); ds = 1'b0;
      chk("nto_xfer", xfer_cnt, 3);
      $display("no timeout: stalled=%0d rdata=%0h xfer=%0d", hi, rdata, xfer_cnt);
   endtask
`endif

   task automatic one_xfer(output bit ok);
      int b = 0;
      rd = 1'b1; be_ack = 1'b1;
      tick();
      rd = 1'b0;
      while (rvalid !== 1'b1 && b < 20) begin b++; tick(); end
      ok = (rvalid === 1'b1);
      ds = 1'b1; tick(); ds = 1'b0;
      be_ack = 1'b0;
   endtask

   task automatic test_wrap();
      bit ok;
      int bad = 0;
      reset_n = 1'b0; #3; reset_n = 1'b1;
      tick();
      for (int i = 0; i < 256; i++) begin
         one_xfer(ok);
         if (!ok) bad++;
         if (i == 254) chk("wrap_255", xfer_cnt, 255);
      end
      chk("wrap_timeouts", bad, 0);
      chk("wrap_zero", xfer_cnt, 0);
      $display("wrap: 256 transactions xfer=%0d stalls=%0d", xfer_cnt, bad);
   endtask

   task automatic test_reset_mid_fetch();
      int n;
      one_xfer(n[0]);
      rd = 1'b1; be_ack = 1'b0; be_data = 8'hC3;
      tick(); tick();
      chk("rmf_bereq_before", be_req, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("rmf_bereq", be_req, 0);
      chk("rmf_ws", ws, 0);
      chk("rmf_rdata", rdata, 0);
      chk("rmf_xfer", xfer_cnt, 0);
      rd = 1'b0;
      tick();
      reset_n = 1'b1;
      rd = 1'b1; be_ack = 1'b1;
      tick();
      rd = 1'b0;
      count_ws(n);
      chk("rmf_restart_ws", n, 3);
      chk("rmf_restart_rdata", rdata, 8'hC3);
      be_ack = 1'b0;
      ds = 1'b1; tick(); ds = 1'b0;
      chk("rmf_restart_xfer", xfer_cnt, 1);
      $display("reset mid-fetch: restart ws_cycles=%0d xfer=%0d", n, xfer_cnt);
   endtask

   // Initiator loop: READ while ws=1 (retry), DONE once data arrives, then ds.
   task automatic test_closed_loop();
      int retries = 0;
      int done = 0;
      int cyc = 0;
      be_ack = 1'b1; be_data = 8'h96; rd = 1'b1;
      tick();
      while (done == 0 && cyc < 50) begin
         cyc++;
         if (ws === 1'b1) begin
            retries++;
            tick();
         end else if (rvalid === 1'b1) begin
            done++;
            rd = 1'b0; ds = 1'b1;
            tick();
            ds = 1'b0;
            chk("loop_rvalid_fall", rvalid, 0);
         end else begin
            tick();
         end
      end
      repeat (3) tick();
      chk("loop_done_once", done, 1);
      chk("loop_retries", retries, 3);
      chk("loop_xfer", xfer_cnt, 2);
      be_ack = 1'b0;
      $display("closed loop: retries=%0d done=%0d xfer=%0d", retries, done, xfer_cnt);
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_slow_backend();
`ifdef FSM1_RSP_TIMEOUT_EN
      test_timeout();
      test_race();
`else
      test_no_timeout();
`endif
      test_wrap();
      test_reset_mid_fetch();
      test_closed_loop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
